// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   state_e : arbiter FSM states
//   grant_e : which core port currently owns the memory
//   XLEN    : address/data width
package mem_arb_pkg;

    localparam int XLEN = 32;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IM   = 2'd1,
        GNT_DM   = 2'd2
    } grant_e;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational grant picker for the memory port arbiter.
// Build option: ARB_ROUND_ROBIN_EN -- with it, simultaneous requests alternate
// against last_grant; without it, dm always wins over im and last_grant is absent.
// Ports:
//   im_req     in  fetch port requesting
//   dm_req     in  data port requesting
//   last_grant in  previous grant (round-robin build only)
//   pick       out port to grant this cycle (GNT_NONE when nobody asks)
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic   im_req,
    input  logic   dm_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  grant_e last_grant,
`endif
    output grant_e pick
);

    // Pick the winner among the pending requests.
    always_comb begin
        pick = GNT_NONE;
        if (im_req && dm_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            // Hand the memory to whichever port did not get it last time.
            if (last_grant == GNT_DM) begin
                pick = GNT_IM;
            end else begin
                pick = GNT_DM;
            end
`else
            pick = GNT_DM;
`endif
        end else if (dm_req) begin
            pick = GNT_DM;
        end else if (im_req) begin
            pick = GNT_IM;
        end else begin
            pick = GNT_NONE;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the core's fetch (im) and data (dm)
// ports using the core's en/busy handshake on both sides. Also flags dm writes
// to the tohost mailbox and raises a sticky timeout when the memory stalls.
// Build option: ARB_ROUND_ROBIN_EN (round-robin on simultaneous requests).
// Ports:
//   clk_i, rst_n_i                  clock, synchronous active-low reset
//   im_en_i/im_addr_i               fetch request; im_dout_o/im_busy_o response
//   dm_en_i/dm_wen_i/dm_addr_i/
//   dm_din_i                        data request; dm_dout_o/dm_busy_o response
//   mem_en_o/mem_wen_o/mem_addr_o/
//   mem_din_o                       memory request side
//   mem_dout_i/mem_busy_i           memory response side
//   tohost_int_o/tohost_data_o      one-cycle mailbox pulse and its data
//   err_timeout_o                   sticky memory timeout flag
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [XLEN-1:0] TOHOST_ADDR    = 32'h8000_1000,
    parameter int              TIMEOUT_CYCLES = 1024
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            im_en_i,
    input  logic [XLEN-1:0] im_addr_i,
    output logic [XLEN-1:0] im_dout_o,
    output logic            im_busy_o,
    input  logic            dm_en_i,
    input  logic            dm_wen_i,
    input  logic [XLEN-1:0] dm_addr_i,
    input  logic [XLEN-1:0] dm_din_i,
    output logic [XLEN-1:0] dm_dout_o,
    output logic            dm_busy_o,
    output logic            mem_en_o,
    output logic            mem_wen_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_din_o,
    input  logic [XLEN-1:0] mem_dout_i,
    input  logic            mem_busy_i,
    output logic            tohost_int_o,
    output logic [XLEN-1:0] tohost_data_o,
    output logic            err_timeout_o
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_e            state_r, state_nxt_s;
    grant_e            grant_r, grant_nxt_s, pick_s;
    logic [XLEN-1:0]   im_dout_r, dm_dout_r, tohost_data_r;
    logic              tohost_int_r, err_r, err_nxt_s;
    logic [CNT_W-1:0]  tmo_cnt_r, tmo_cnt_nxt_s;
    logic              done_s, im_done_s, dm_done_s;
    logic              im_rd_done_s, dm_rd_done_s, tohost_hit_s;

`ifdef ARB_ROUND_ROBIN_EN
    grant_e            last_grant_r;

    // Remember who was granted most recently, for round-robin fairness.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_grant_r <= GNT_IM;
        end else if (state_r == ST_IDLE && (im_en_i || dm_en_i)) begin
            last_grant_r <= pick_s;
        end
    end
`endif

    mem_arb_picker u_picker (
        .im_req     (im_en_i),
        .dm_req     (dm_en_i),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant (last_grant_r),
`endif
        .pick       (pick_s)
    );

    // Route the granted port onto the memory bus; the bus is quiet in IDLE.
    // The access keeps running even if the requester drops en, so writes never tear.
    always_comb begin
        mem_en_o   = 1'b0;
        mem_wen_o  = 1'b0;
        mem_addr_o = 32'h0000_0000;
        mem_din_o  = 32'h0000_0000;
        if (state_r == ST_ACCESS) begin
            case (grant_r)
                GNT_IM: begin
                    mem_en_o   = 1'b1;
                    mem_addr_o = im_addr_i;
                end
                GNT_DM: begin
                    mem_en_o   = 1'b1;
                    mem_wen_o  = dm_wen_i;
                    mem_addr_o = dm_addr_i;
                    mem_din_o  = dm_din_i;
                end
                default: begin
                    mem_en_o   = 1'b0;
                end
            endcase
        end else begin
            mem_en_o = 1'b0;
        end
    end

    assign done_s       = mem_en_o & ~mem_busy_i;
    assign im_done_s    = done_s & (grant_r == GNT_IM);
    assign dm_done_s    = done_s & (grant_r == GNT_DM);
    // Read data is only delivered to a requester that is still asking for it.
    assign im_rd_done_s = im_done_s & im_en_i;
    assign dm_rd_done_s = dm_done_s & dm_en_i & ~dm_wen_i;
    assign tohost_hit_s = dm_done_s & mem_wen_o & (mem_addr_o == TOHOST_ADDR);

    assign im_busy_o = im_en_i & ~im_done_s;
    assign dm_busy_o = dm_en_i & ~dm_done_s;

    // FSM next state and grant latch.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        case (state_r)
            ST_IDLE: begin
                if (im_en_i || dm_en_i) begin
                    state_nxt_s = ST_ACCESS;
                    grant_nxt_s = pick_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = GNT_NONE;
                end
            end
            ST_ACCESS: begin
                // An ACCESS without an owner can never complete; fall back to IDLE.
                if (done_s || grant_r == GNT_NONE) begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = GNT_NONE;
                end else begin
                    state_nxt_s = ST_ACCESS;
                    grant_nxt_s = grant_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = GNT_NONE;
            end
        endcase
    end

    // Stall counter: counts busy ACCESS cycles, saturates at the limit, clears on completion.
    always_comb begin
        tmo_cnt_nxt_s = tmo_cnt_r;
        if (done_s) begin
            tmo_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (state_r == ST_ACCESS && mem_busy_i && tmo_cnt_r != TMO_MAX) begin
            tmo_cnt_nxt_s = tmo_cnt_r + CNT_W'(1);
        end else begin
            tmo_cnt_nxt_s = tmo_cnt_r;
        end
        err_nxt_s = err_r | (tmo_cnt_nxt_s == TMO_MAX);
    end

    // Read data presented combinationally in the completion cycle, held afterwards.
    always_comb begin
        if (im_rd_done_s) begin
            im_dout_o = mem_dout_i;
        end else begin
            im_dout_o = im_dout_r;
        end
        if (dm_rd_done_s) begin
            dm_dout_o = mem_dout_i;
        end else begin
            dm_dout_o = dm_dout_r;
        end
    end

    // FSM state and grant registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
            grant_r <= GNT_NONE;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
        end
    end

    // Capture read data at each port's read completion.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            im_dout_r <= 32'h0000_0000;
            dm_dout_r <= 32'h0000_0000;
        end else begin
            if (im_rd_done_s) begin
                im_dout_r <= mem_dout_i;
            end
            if (dm_rd_done_s) begin
                dm_dout_r <= mem_dout_i;
            end
        end
    end

    // Mailbox pulse, and stall counter with its sticky error flag.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tohost_int_r  <= 1'b0;
            tohost_data_r <= 32'h0000_0000;
            tmo_cnt_r     <= {CNT_W{1'b0}};
            err_r         <= 1'b0;
        end else begin
            tohost_int_r  <= tohost_hit_s;
            tohost_data_r <= tohost_hit_s ? mem_din_o : 32'h0000_0000;
            tmo_cnt_r     <= tmo_cnt_nxt_s;
            err_r         <= err_nxt_s;
        end
    end

    assign tohost_int_o  = tohost_int_r;
    assign tohost_data_o = tohost_data_r;
    assign err_timeout_o = err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: tasks push expected responses, a
// negedge monitor pops and compares whenever a port completes or tohost pulses.
module tb_mem_port_arbiter;

    localparam int K_IM  = 0;
    localparam int K_DMR = 1;
    localparam int K_DMW = 2;
    localparam int K_TH  = 3;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        im_en = 1'b0;
    logic [31:0] im_addr = 32'h0;
    logic [31:0] im_dout;
    logic        im_busy;
    logic        dm_en = 1'b0;
    logic        dm_wen = 1'b0;
    logic [31:0] dm_addr = 32'h0;
    logic [31:0] dm_din = 32'h0;
    logic [31:0] dm_dout;
    logic        dm_busy;
    logic        mem_en, mem_wen;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        mem_busy = 1'b0;
    logic        tohost_int;
    logic [31:0] tohost_data;
    logic        err_timeout;

    logic [31:0] mem [0:15];
    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .im_en_i(im_en), .im_addr_i(im_addr), .im_dout_o(im_dout), .im_busy_o(im_busy),
        .dm_en_i(dm_en), .dm_wen_i(dm_wen), .dm_addr_i(dm_addr), .dm_din_i(dm_din),
        .dm_dout_o(dm_dout), .dm_busy_o(dm_busy),
        .mem_en_o(mem_en), .mem_wen_o(mem_wen), .mem_addr_o(mem_addr), .mem_din_o(mem_din),
        .mem_dout_i(mem_dout), .mem_busy_i(mem_busy),
        .tohost_int_o(tohost_int), .tohost_data_o(tohost_data), .err_timeout_o(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic int midx(input logic [31:0] a);
        return int'({a[12], a[4:2]});
    endfunction

    // Tiny memory model: combinational read, write on completion.
    assign mem_dout = mem[midx(mem_addr)];
    always @(posedge clk) begin
        if (mem_en && mem_wen && !mem_busy) mem[midx(mem_addr)] <= mem_din;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic pop_cmp(input int kind, input logic [31:0] act);
        exp_t e;
        if (sb.size() == 0) begin
            check("unexpected_response", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = sb.pop_front();
            check("resp_kind", 32'(kind), 32'(e.kind));
            check("resp_data", act, e.data);
        end
    endtask

    // Monitor: compare every DUT response against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tohost_int) pop_cmp(K_TH, tohost_data);
            if (im_en && !im_busy) pop_cmp(K_IM, im_dout);
            if (dm_en && !dm_busy) pop_cmp(dm_wen ? K_DMW : K_DMR, dm_dout);
        end
    end

    task automatic im_read(input logic [31:0] a, input logic [31:0] exp, output int bc);
        bit done = 1'b0;
        sb.push_back('{K_IM, exp});
        im_en = 1'b1; im_addr = a; bc = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (!im_busy) done = 1'b1; else bc++;
        end
        if (!done) check("im_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        im_en = 1'b0;
    endtask

    task automatic dm_acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp, output logic wen_seen);
        bit done = 1'b0;
        sb.push_back('{w ? K_DMW : K_DMR, exp});
        dm_en = 1'b1; dm_wen = w; dm_addr = a; dm_din = d; wen_seen = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (!dm_busy) begin done = 1'b1; wen_seen = mem_wen; end
        end
        if (!done) check("dm_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        dm_en = 1'b0; dm_wen = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bc;
        logic ws;
        bit   im_d, dm_d;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h0000_0013; mem[1] = 32'h0050_0093; mem[2] = 32'hCAFE_F00D;
        mem[3] = 32'h0BAD_C0DE; mem[4] = 32'h0000_1234; mem[5] = 32'h1111_1111;

        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        // Reset state
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_im_busy", 32'(im_busy), 32'd0);
        check("rst_dm_dout", dm_dout, 32'h0);
        check("rst_tohost", 32'(tohost_int), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);

        // 1: single fetch, zero-wait memory
        im_read(32'h8000_0000, 32'h0000_0013, bc);
        check("t1_busy_cycles", 32'(bc), 32'd1);

        // 2: dm write to tohost mailbox
        sb.push_back('{K_DMW, 32'h0});
        sb.delete(sb.size() - 1);
        dm_acc(1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 32'h0, ws);
        sb.push_back('{K_TH, 32'hDEAD_BEEF});
        check("t2_mem_wen", 32'(ws), 32'd1);
        check("t2_tohost_pulse", 32'(tohost_int), 32'd1);
        check("t2_tohost_data", tohost_data, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check("t2_tohost_clr", 32'(tohost_int), 32'd0);
        check("t2_tohost_dclr", tohost_data, 32'h0);

        // 3: simultaneous requests, dm first then im
        sb.push_back('{K_DMR, 32'hCAFE_F00D});
        sb.push_back('{K_IM, 32'h0050_0093});
        im_en = 1'b1; im_addr = 32'h8000_0004;
        dm_en = 1'b1; dm_wen = 1'b0; dm_addr = 32'h8000_0008;
        im_d = 1'b0; dm_d = 1'b0;
        for (int i = 0; i < 64 && !(im_d && dm_d); i++) begin
            @(negedge clk);
            if (im_en && !im_busy) im_d = 1'b1;
            if (dm_en && !dm_busy) dm_d = 1'b1;
            @(posedge clk); #1;
            if (im_d) im_en = 1'b0;
            if (dm_d) dm_en = 1'b0;
        end
        check("t3_both_done", 32'({im_d, dm_d}), 32'd3);
        im_en = 1'b0; dm_en = 1'b0;

        // 4: memory stalls past the timeout limit (8)
        mem_busy = 1'b1;
        sb.push_back('{K_DMR, 32'h0BAD_C0DE});
        dm_en = 1'b1; dm_wen = 1'b0; dm_addr = 32'h8000_000C;
        @(posedge clk); #1;
        repeat (7) begin @(posedge clk); #1; end
        check("t4_err_before", 32'(err_timeout), 32'd0);
        @(posedge clk); #1;
        check("t4_err_set", 32'(err_timeout), 32'd1);
        repeat (3) begin @(posedge clk); #1; end
        check("t4_err_sticky", 32'(err_timeout), 32'd1);
        check("t4_still_busy", 32'(dm_busy), 32'd1);
        mem_busy = 1'b0;
        @(posedge clk); #1;
        dm_en = 1'b0;
        check("t4_err_after", 32'(err_timeout), 32'd1);
        check("t4_dm_dout", dm_dout, 32'h0BAD_C0DE);

        // 5: reset in the middle of an access
        mem_busy = 1'b1;
        im_en = 1'b1; im_addr = 32'h8000_0014;
        repeat (2) begin @(posedge clk); #1; end
        check("t5_in_access", 32'(mem_en), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t5_mem_en", 32'(mem_en), 32'd0);
        check("t5_im_busy", 32'(im_busy), 32'd1);
        check("t5_dm_busy", 32'(dm_busy), 32'd0);
        check("t5_im_dout", im_dout, 32'h0);
        check("t5_dm_dout", dm_dout, 32'h0);
        check("t5_err", 32'(err_timeout), 32'd0);
        im_en = 1'b0; mem_busy = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        // 6: dm read result survives later fetches
        dm_acc(1'b0, 32'h8000_0010, 32'h0, 32'h0000_1234, ws);
        im_read(32'h8000_0000, 32'h0000_0013, bc);
        check("t6_dm_hold1", dm_dout, 32'h0000_1234);
        im_read(32'h8000_0014, 32'h1111_1111, bc);
        check("t6_dm_hold2", dm_dout, 32'h0000_1234);
        check("t6_im_dout", im_dout, 32'h1111_1111);

        repeat (2) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
